// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue arbiter and its queue.
package pq_pkg;

  localparam int KW          = 16;
  localparam int VW          = 16;
  localparam int PQ_CAPACITY = 8;

  localparam logic [KW-1:0] KEYINF = '1;

  typedef struct packed {
    logic [KW-1:0] key;
    logic [VW-1:0] value;
  } kv_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_SETTLE
  } arb_state_e;

endpackage

// File: rtl/pq_arb_rr_pick.sv
// Combinational round-robin selector: first set bit of elig_i at or after
// ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    int cand;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found_o && elig_i[IW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pq_arb.sv
// Round-robin arbiter sharing one priority queue among NCLIENT requesters,
// with occupancy tracking, full blocking and local answers to empty pops.
module pq_arb
  import pq_pkg::*;
#(
  parameter int NCLIENT = 4,
  parameter int SETTLE  = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NCLIENT-1:0]               c_push,
  input  logic [NCLIENT-1:0]               c_pop,
  input  kv_t  [NCLIENT-1:0]               c_kvi,
  output logic [NCLIENT-1:0]               c_ack,
  output kv_t                              c_kvo,
  output logic                             c_pop_empty,
  output logic                             pq_push,
  output logic                             pq_pop,
  output kv_t                              pq_kvi,
  input  kv_t                              pq_kvo,
  output logic [$clog2(PQ_CAPACITY+1)-1:0] count,
  output logic                             full,
  output logic                             empty
);

  localparam int IW = $clog2(NCLIENT);
  localparam int CW = $clog2(PQ_CAPACITY + 1);

  arb_state_e          state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       idx_q;
  logic [1:0]          settle_q;
  logic [CW-1:0]       count_q;
  logic [NCLIENT-1:0]  c_ack_q;
  logic                pq_push_q;
  logic                pq_pop_q;
  kv_t                 pq_kvi_q;
  kv_t                 c_kvo_q;
  logic                c_pop_empty_q;

  logic [NCLIENT-1:0]  elig;
  logic [IW-1:0]       pick;
  logic                found;

  assign full  = (count_q == CW'(PQ_CAPACITY));
  assign empty = (count_q == '0);

  // A pending pop is always serviceable; a push only while space remains.
  assign elig = c_pop | (c_push & {NCLIENT{~full}});

  rr_pick #(
    .N (NCLIENT)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .idx_o   (pick),
    .found_o (found)
  );

  // The grant-cycle outputs are loaded on entry to GRANT. The queue is idle
  // between grants, so its head sampled in IDLE equals the head in GRANT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= '0;
      idx_q         <= '0;
      settle_q      <= '0;
      count_q       <= '0;
      c_ack_q       <= '0;
      pq_push_q     <= 1'b0;
      pq_pop_q      <= 1'b0;
      pq_kvi_q      <= '0;
      c_kvo_q       <= {KEYINF, {VW{1'b0}}};
      c_pop_empty_q <= 1'b0;
    end else begin
      c_ack_q   <= '0;
      pq_push_q <= 1'b0;
      pq_pop_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (found) begin
            state_q <= ARB_GRANT;
            idx_q   <= pick;
            c_ack_q <= NCLIENT'(1) << pick;
            if (c_pop[pick]) begin
              c_pop_empty_q <= empty;
              if (empty) begin
                c_kvo_q <= {KEYINF, {VW{1'b0}}};
              end else begin
                pq_pop_q <= 1'b1;
                c_kvo_q  <= pq_kvo;
              end
            end else begin
              pq_push_q <= 1'b1;
              pq_kvi_q  <= c_kvi[pick];
            end
          end
        end
        ARB_GRANT: begin
          if (pq_push_q) begin
            count_q <= count_q + CW'(1);
          end else if (pq_pop_q) begin
            count_q <= count_q - CW'(1);
          end
          ptr_q    <= (idx_q == IW'(NCLIENT - 1)) ? '0 : idx_q + IW'(1);
          settle_q <= '0;
          state_q  <= (SETTLE > 0) ? ARB_SETTLE : ARB_IDLE;
        end
        ARB_SETTLE: begin
          if (settle_q == 2'(SETTLE - 1)) begin
            state_q <= ARB_IDLE;
          end else begin
            settle_q <= settle_q + 2'd1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign c_ack       = c_ack_q;
  assign pq_push     = pq_push_q;
  assign pq_pop      = pq_pop_q;
  assign pq_kvi      = pq_kvi_q;
  assign c_kvo       = c_kvo_q;
  assign c_pop_empty = c_pop_empty_q;
  assign count       = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    pq_push |-> (count_q != CW'(PQ_CAPACITY)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    pq_pop |-> (count_q != '0));

endmodule

// File: tb/tb_pq_arb.sv
// Self-checking bench for pq_arb: a behavioural priority queue plays the
// device side, a sorted-multiset reference predicts client-visible results.
module tb_pq_arb;
  import pq_pkg::*;

  localparam int NCLIENT = 4;
  localparam int SETTLE  = 1;
  localparam int CW      = $clog2(PQ_CAPACITY + 1);

  logic               clk;
  logic               rst_n;
  logic [NCLIENT-1:0] c_push;
  logic [NCLIENT-1:0] c_pop;
  kv_t  [NCLIENT-1:0] c_kvi;
  logic [NCLIENT-1:0] c_ack;
  kv_t                c_kvo;
  logic               c_pop_empty;
  logic               pq_push;
  logic               pq_pop;
  kv_t                pq_kvi;
  kv_t                pq_kvo;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pushStrobes = 0;
  int popStrobes = 0;

  kv_t pqMem[$];
  int  refKeys[$];
  int  devMin;

  pq_arb #(
    .NCLIENT (NCLIENT),
    .SETTLE  (SETTLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .c_push      (c_push),
    .c_pop       (c_pop),
    .c_kvi       (c_kvi),
    .c_ack       (c_ack),
    .c_kvo       (c_kvo),
    .c_pop_empty (c_pop_empty),
    .pq_push     (pq_push),
    .pq_pop      (pq_pop),
    .pq_kvi      (pq_kvi),
    .pq_kvo      (pq_kvo),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pq_push) pushStrobes++;
    if (pq_pop) popStrobes++;
  end

  // Device-side queue: head is the smallest key, oldest first on ties.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pqMem.delete();
      pq_kvo <= {KEYINF, {VW{1'b0}}};
    end else begin
      if (pq_pop && pqMem.size() > 0) begin
        devMin = 0;
        for (int i = 1; i < pqMem.size(); i++)
          if (pqMem[i].key < pqMem[devMin].key) devMin = i;
        pqMem.delete(devMin);
      end
      if (pq_push) begin
        checks++;
        if (pqMem.size() >= PQ_CAPACITY) begin
          errors++;
          $display("[TB] FAIL push_on_full: queue held %0d, capacity %0d", pqMem.size(), PQ_CAPACITY);
        end
        pqMem.push_back(pq_kvi);
      end
      if (pqMem.size() == 0) begin
        pq_kvo <= {KEYINF, {VW{1'b0}}};
      end else begin
        devMin = 0;
        for (int i = 1; i < pqMem.size(); i++)
          if (pqMem[i].key < pqMem[devMin].key) devMin = i;
        pq_kvo <= pqMem[devMin];
      end
    end
  end

  function automatic int refPopMin();
    int mi = 0;
    int k;
    for (int i = 1; i < refKeys.size(); i++)
      if (refKeys[i] < refKeys[mi]) mi = i;
    k = refKeys[mi];
    refKeys.delete(mi);
    return k;
  endfunction

  function automatic logic [VW-1:0] valOf(input logic [KW-1:0] k);
    return VW'(k ^ 16'h5A5A);
  endfunction

  task automatic doReset();
    rst_n  = 1'b0;
    c_push = '0;
    c_pop  = '0;
    c_kvi  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    refKeys.delete();
    @(negedge clk);
  endtask

  // Drives one request, waits (bounded) for the ack, captures the grant-cycle
  // outputs, releases the request and lets the settle gap pass.
  task automatic doOp(input int client, input bit isPop, input logic [KW-1:0] k,
                      output logic [NCLIENT-1:0] ackSeen, output kv_t kvoSeen,
                      output logic emptySeen);
    int lat = 0;
    c_kvi[client] = {k, valOf(k)};
    if (isPop) c_pop[client] = 1'b1;
    else c_push[client] = 1'b1;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (c_ack != '0) break;
    end
    ackSeen   = c_ack;
    kvoSeen   = c_kvo;
    emptySeen = c_pop_empty;
    c_pop[client]  = 1'b0;
    c_push[client] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitAnyAck(output logic [NCLIENT-1:0] ackSeen, output int when);
    int lat = 0;
    ackSeen = '0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (c_ack != '0) break;
    end
    ackSeen = c_ack;
    when    = cyc;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({c_ack, pq_push, pq_pop, c_pop_empty} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got ack=%b push=%b pop=%b pe=%b, expected all 0", c_ack, pq_push, pq_pop, c_pop_empty);
    end
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_count: got count=%0d empty=%b full=%b, expected 0/1/0", count, empty, full);
    end
    checks++;
    if (c_kvo !== {KEYINF, {VW{1'b0}}} || pq_kvi !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got kvo=%h kvi=%h, expected %h/0", c_kvo, pq_kvi, {KEYINF, {VW{1'b0}}});
    end
  endtask

  task automatic test_push_pop();
    logic [NCLIENT-1:0] a;
    kv_t kv;
    logic pe;
    doReset();
    doOp(0, 1'b0, 16'd5, a, kv, pe);
    checks++;
    if (a !== 4'b0001 || count !== CW'(1)) begin
      errors++;
      $display("[TB] FAIL push_basic: got ack=%b count=%0d, expected 0001/1", a, count);
    end
    doOp(0, 1'b1, 16'd0, a, kv, pe);
    checks++;
    if (a !== 4'b0001 || kv !== {16'd5, valOf(16'd5)} || pe !== 1'b0 || count !== '0) begin
      errors++;
      $display("[TB] FAIL pop_basic: got ack=%b kv=%h pe=%b count=%0d, expected 0001/%h/0/0", a, kv, pe, count, {16'd5, valOf(16'd5)});
    end
  endtask

  task automatic test_empty_pop();
    logic [NCLIENT-1:0] a;
    kv_t kv;
    logic pe;
    int strobesBefore;
    doReset();
    strobesBefore = popStrobes;
    doOp(2, 1'b1, 16'd0, a, kv, pe);
    checks++;
    if (a !== 4'b0100 || pe !== 1'b1 || kv.key !== KEYINF) begin
      errors++;
      $display("[TB] FAIL empty_pop: got ack=%b pe=%b key=%h, expected 0100/1/%h", a, pe, kv.key, KEYINF);
    end
    checks++;
    if (popStrobes !== strobesBefore || count !== '0) begin
      errors++;
      $display("[TB] FAIL empty_pop_strobe: got strobes=%0d count=%0d, expected %0d/0", popStrobes - strobesBefore, count, 0);
    end
  endtask

  task automatic test_fairness();
    logic [NCLIENT-1:0] a;
    kv_t kv;
    logic pe;
    int when;
    int prev;
    int keys[4] = '{9, 3, 7, 1};
    int expPop[4] = '{1, 3, 7, 9};
    doReset();
    for (int i = 0; i < NCLIENT; i++) c_kvi[i] = {KW'(keys[i]), valOf(KW'(keys[i]))};
    c_push = '1;
    prev = 0;
    for (int n = 0; n < NCLIENT; n++) begin
      waitAnyAck(a, when);
      checks++;
      if (a !== (4'(1) << n)) begin
        errors++;
        $display("[TB] FAIL rr_order%0d: got ack=%b, expected %b", n, a, 4'(1) << n);
      end
      if (n > 0) begin
        checks++;
        if (when - prev !== 2 + SETTLE) begin
          errors++;
          $display("[TB] FAIL rr_spacing%0d: got %0d cycles, expected %0d", n, when - prev, 2 + SETTLE);
        end
      end
      prev = when;
      c_push = c_push & ~a;
      refKeys.push_back(keys[n]);
    end
    c_push = '0;
    repeat (2) @(negedge clk);
    for (int n = 0; n < NCLIENT; n++) begin
      doOp(0, 1'b1, 16'd0, a, kv, pe);
      checks++;
      if (kv.key !== KW'(expPop[n]) || kv.key !== KW'(refPopMin())) begin
        errors++;
        $display("[TB] FAIL prio_pop%0d: got key=%0d, expected %0d", n, kv.key, expPop[n]);
      end
    end
  endtask

  task automatic test_full();
    logic [NCLIENT-1:0] a;
    kv_t kv;
    logic pe;
    int when;
    int acks;
    int strobesBefore;
    logic [KW-1:0] k;
    doReset();
    for (int i = 0; i < PQ_CAPACITY; i++) begin
      k = KW'($urandom_range(10, 500));
      doOp(0, 1'b0, k, a, kv, pe);
      refKeys.push_back(int'(k));
    end
    checks++;
    if (full !== 1'b1 || count !== CW'(PQ_CAPACITY)) begin
      errors++;
      $display("[TB] FAIL fill: got full=%b count=%0d, expected 1/%0d", full, count, PQ_CAPACITY);
    end
    strobesBefore = pushStrobes;
    c_kvi[1] = {16'd3, valOf(16'd3)};
    c_push[1] = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (c_ack != '0) acks++;
    end
    checks++;
    if (acks !== 0 || pushStrobes !== strobesBefore) begin
      errors++;
      $display("[TB] FAIL blocked_push: got acks=%0d strobes=%0d, expected 0/0", acks, pushStrobes - strobesBefore);
    end
    c_pop[3] = 1'b1;
    waitAnyAck(a, when);
    c_pop[3] = 1'b0;
    checks++;
    if (a !== 4'b1000 || c_kvo.key !== KW'(refPopMin())) begin
      errors++;
      $display("[TB] FAIL full_pop: got ack=%b key=%0d, expected 1000 and model minimum", a, c_kvo.key);
    end
    waitAnyAck(a, when);
    c_push[1] = 1'b0;
    refKeys.push_back(3);
    repeat (2) @(negedge clk);
    checks++;
    if (a !== 4'b0010 || count !== CW'(PQ_CAPACITY) || full !== 1'b1) begin
      errors++;
      $display("[TB] FAIL unblocked_push: got ack=%b count=%0d, expected 0010/%0d", a, count, PQ_CAPACITY);
    end
  endtask

  task automatic test_push_pop_same();
    logic [NCLIENT-1:0] a;
    kv_t kv;
    logic pe;
    int when;
    doReset();
    doOp(1, 1'b0, 16'd2, a, kv, pe);
    c_kvi[2] = {16'd4, valOf(16'd4)};
    c_push[2] = 1'b1;
    c_pop[2]  = 1'b1;
    waitAnyAck(a, when);
    c_pop[2] = 1'b0;
    checks++;
    if (a !== 4'b0100 || c_kvo.key !== 16'd2 || c_pop_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_pop_first: got ack=%b key=%0d pe=%b, expected 0100/2/0", a, c_kvo.key, c_pop_empty);
    end
    waitAnyAck(a, when);
    c_push[2] = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a !== 4'b0100 || count !== CW'(1)) begin
      errors++;
      $display("[TB] FAIL same_push_second: got ack=%b count=%0d, expected 0100/1", a, count);
    end
    doOp(0, 1'b1, 16'd0, a, kv, pe);
    checks++;
    if (kv.key !== 16'd4) begin
      errors++;
      $display("[TB] FAIL same_pushed_key: got key=%0d, expected 4", kv.key);
    end
  endtask

  task automatic test_random();
    logic [NCLIENT-1:0] a;
    kv_t kv;
    logic pe;
    int client;
    bit isPop;
    int expKey;
    logic [KW-1:0] k;
    doReset();
    for (int n = 0; n < 40; n++) begin
      client = $urandom_range(0, NCLIENT - 1);
      if (refKeys.size() == PQ_CAPACITY) isPop = 1'b1;
      else if (refKeys.size() == 0) isPop = ($urandom_range(0, 3) == 0);
      else isPop = $urandom_range(0, 1) == 1;
      k = KW'($urandom_range(0, 999));
      doOp(client, isPop, k, a, kv, pe);
      checks++;
      if (a !== (4'(1) << client)) begin
        errors++;
        $display("[TB] FAIL rand_ack%0d: got %b, expected %b", n, a, 4'(1) << client);
      end
      if (isPop) begin
        if (refKeys.size() == 0) begin
          checks++;
          if (pe !== 1'b1 || kv.key !== KEYINF) begin
            errors++;
            $display("[TB] FAIL rand_empty%0d: got pe=%b key=%h, expected 1/%h", n, pe, kv.key, KEYINF);
          end
        end else begin
          expKey = refPopMin();
          checks++;
          if (pe !== 1'b0 || kv.key !== KW'(expKey)) begin
            errors++;
            $display("[TB] FAIL rand_pop%0d: got pe=%b key=%0d, expected 0/%0d", n, pe, kv.key, expKey);
          end
        end
      end else begin
        refKeys.push_back(int'(k));
      end
      checks++;
      if (count !== CW'(refKeys.size())) begin
        errors++;
        $display("[TB] FAIL rand_count%0d: got %0d, expected %0d", n, count, refKeys.size());
      end
    end
  endtask

  task automatic test_reset_in_grant();
    logic [NCLIENT-1:0] a;
    int when;
    doReset();
    c_kvi[1] = {16'd7, valOf(16'd7)};
    c_push[1] = 1'b1;
    waitAnyAck(a, when);
    rst_n = 1'b0;
    #1;
    checks++;
    if (a !== 4'b0010 || c_ack !== '0 || pq_push !== 1'b0 || count !== '0 || c_kvo.key !== KEYINF || c_pop_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got pre-ack=%b ack=%b push=%b count=%0d key=%h", a, c_ack, pq_push, count, c_kvo.key);
    end
    c_push = '0;
    @(negedge clk);
    rst_n = 1'b1;
    refKeys.delete();
    @(negedge clk);
    c_kvi[0] = {16'd8, valOf(16'd8)};
    c_kvi[2] = {16'd6, valOf(16'd6)};
    c_push = 4'b0101;
    waitAnyAck(a, when);
    c_push = c_push & ~a;
    checks++;
    if (a !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_ptr: got ack=%b, expected 0001", a);
    end
    waitAnyAck(a, when);
    c_push = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (a !== 4'b0100 || count !== CW'(2)) begin
      errors++;
      $display("[TB] FAIL reset_after: got ack=%b count=%0d, expected 0100/2", a, count);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    c_push = '0;
    c_pop  = '0;
    c_kvi  = '0;
    $display("[TB] starting pq_arb bench");
    test_reset();
    test_push_pop();
    test_empty_pop();
    test_fairness();
    test_full();
    test_push_pop_same();
    test_random();
    test_reset_in_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
